// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Conditions the board's raw active-low push buttons before any application
//   logic uses them. Each key is handled independently: a 2-FF synchroniser
//   brings the asynchronous pin into the FPGA_CLK domain, then a 4-state
//   counter-based debouncer accepts a level change only after DB_CYCLES
//   consecutive synchronised samples agree.
//
// Parameters
//   N_KEYS     number of independent keys
//   DB_CYCLES  consecutive stable samples required to accept a change (>= 2)
//
// Ports
//   FPGA_CLK     in   1       system clock, all logic on rising edge
//   FPGA_RST     in   1       synchronous reset, active-high
//   KEY          in   N_KEYS  raw buttons, asynchronous, 0 = pressed
//   key_level    out  N_KEYS  debounced state, 1 = pressed
//   key_press    out  N_KEYS  one-cycle pulse on a debounced press
//   key_release  out  N_KEYS  one-cycle pulse on a debounced release
//   key_toggle   out  N_KEYS  flips on every debounced press
//
// All outputs are registered. Per-key FSM state is held in state_q[] and the
// run counter in cnt_q[], both visible for hierarchical inspection.
//
// Handshake: there is none; KEY is a free-running level input and every
// output is a plain registered level/pulse, valid on every cycle.
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int N_KEYS    = 4,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic              FPGA_CLK,
  input  logic              FPGA_RST,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_toggle
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  // Terminal count: the sample that completes a run of DB_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_PEND   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } db_state_e;

  // Synchroniser stages; reset to 1 so a reset looks like "not pressed".
  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  // Synchronised key, 1 = pressed.
  logic [N_KEYS-1:0] pressed_n;

  db_state_e         state_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_q   [N_KEYS];

  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_n = ~sync2_q;

  // One FSM per key, unrolled by the loop; keys never interact.
  // The counter holds the length of the current contrary run; it is cleared on
  // every reversal, so it can never go past CNT_LAST.
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      for (int k = 0; k < N_KEYS; k++) begin
        state_q[k] <= ST_RELEASED;
        cnt_q[k]   <= '0;
      end
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_toggle  <= '0;
    end else begin
      // Pulses are single-cycle unless re-asserted below.
      key_press   <= '0;
      key_release <= '0;
      for (int k = 0; k < N_KEYS; k++) begin
        case (state_q[k])
          ST_RELEASED: begin
            if (pressed_n[k]) begin
              state_q[k] <= ST_PRESS_PEND;
              cnt_q[k]   <= CNT_W'(1);
            end else begin
              cnt_q[k]   <= '0;
            end
          end
          ST_PRESS_PEND: begin
            if (!pressed_n[k]) begin
              // Run too short: treat as a glitch.
              state_q[k] <= ST_RELEASED;
              cnt_q[k]   <= '0;
            end else if (cnt_q[k] == CNT_LAST) begin
              state_q[k]    <= ST_PRESSED;
              cnt_q[k]      <= '0;
              key_level[k]  <= 1'b1;
              key_press[k]  <= 1'b1;
              key_toggle[k] <= ~key_toggle[k];
            end else begin
              cnt_q[k]   <= cnt_q[k] + CNT_W'(1);
            end
          end
          ST_PRESSED: begin
            if (!pressed_n[k]) begin
              state_q[k] <= ST_RELEASE_PEND;
              cnt_q[k]   <= CNT_W'(1);
            end
          end
          ST_RELEASE_PEND: begin
            if (pressed_n[k]) begin
              state_q[k] <= ST_PRESSED;
              cnt_q[k]   <= '0;
            end else if (cnt_q[k] == CNT_LAST) begin
              state_q[k]     <= ST_RELEASED;
              cnt_q[k]       <= '0;
              key_level[k]   <= 1'b0;
              key_release[k] <= 1'b1;
            end else begin
              cnt_q[k]   <= cnt_q[k] + CNT_W'(1);
            end
          end
          default: begin
            state_q[k] <= ST_RELEASED;
            cnt_q[k]   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

  localparam int NK = 4;
  localparam int DB = 8;

  logic          FPGA_CLK;
  logic          FPGA_RST;
  logic [NK-1:0] KEY;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_toggle;

  int n_checks = 0;
  int n_errors = 0;

  key_debounce #(.N_KEYS(NK), .DB_CYCLES(DB)) dut (
    .FPGA_CLK    (FPGA_CLK),
    .FPGA_RST    (FPGA_RST),
    .KEY         (KEY),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_toggle  (key_toggle)
  );

  // ---------------------------------------------------------------- clock/reset
  initial FPGA_CLK = 1'b0;
  always #5 FPGA_CLK = ~FPGA_CLK;

  // ---------------------------------------------------------------- vectors
  // Each record is one clock edge: inputs held across the edge and the
  // outputs {level, press, release, toggle} expected just after it.
  typedef struct {
    string         name;
    logic          rst;
    logic [NK-1:0] key;
    logic [4*NK-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input int cnt, input logic rst,
                     input logic [NK-1:0] key, input logic [NK-1:0] lvl,
                     input logic [NK-1:0] prs, input logic [NK-1:0] rel,
                     input logic [NK-1:0] tog);
    vec_t v;
    v.name = name;
    v.rst  = rst;
    v.key  = key;
    v.exp  = {lvl, prs, rel, tog};
    for (int i = 0; i < cnt; i++) vecs.push_back(v);
  endtask

  // ---------------------------------------------------------------- reference model
  // A key's debounced level flips when the last DB synchronised samples all
  // disagree with it. Samples are kept as a sliding window per key.
  logic [NK-1:0]   m_s1, m_s2;
  logic [DB-1:0]   m_hist [NK];
  logic [NK-1:0]   m_level, m_press, m_rel, m_tog;
  logic [4*NK-1:0] exp_q[$];

  task automatic model_step(input logic rst, input logic [NK-1:0] key);
    logic [NK-1:0] n;
    if (rst) begin
      m_s1 = '1;
      m_s2 = '1;
      for (int k = 0; k < NK; k++) m_hist[k] = '0;
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      m_tog   = '0;
    end else begin
      n       = ~m_s2;
      m_s2    = m_s1;
      m_s1    = key;
      m_press = '0;
      m_rel   = '0;
      for (int k = 0; k < NK; k++) begin
        m_hist[k] = {m_hist[k][DB-2:0], n[k]};
        if (!m_level[k] && m_hist[k] == {DB{1'b1}}) begin
          m_level[k] = 1'b1;
          m_press[k] = 1'b1;
          m_tog[k]   = ~m_tog[k];
        end else if (m_level[k] && m_hist[k] == {DB{1'b0}}) begin
          m_level[k] = 1'b0;
          m_rel[k]   = 1'b1;
        end
      end
    end
    exp_q.push_back({m_level, m_press, m_rel, m_tog});
  endtask

  // ---------------------------------------------------------------- driver / checker
  task automatic check(input string name, input logic [4*NK-1:0] exp);
    logic [4*NK-1:0] got;
    got = {key_level, key_press, key_release, key_toggle};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got lvl/prs/rel/tog=%b_%b_%b_%b required %b_%b_%b_%b",
               name, $time, got[15:12], got[11:8], got[7:4], got[3:0],
               exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic drive_cycle(input logic rst, input logic [NK-1:0] key);
    FPGA_RST = rst;
    KEY      = key;
    @(posedge FPGA_CLK);
    #1;
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [NK-1:0] cur_key;
  int            seg_left [NK];
  logic          rnd_rst;

  initial begin
    FPGA_RST = 1'b1;
    KEY      = '1;

    // Reset with all keys held down; all four press together.
    add("t1_rst",     3, 1'b1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0);
    add("t1_wait",    9, 1'b0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0);
    add("t1_press",   1, 1'b0, 4'b0000, 4'hF, 4'hF, 4'h0, 4'hF);
    add("t1_hold",    1, 1'b0, 4'b0000, 4'hF, 4'h0, 4'h0, 4'hF);
    add("t1_relwait", 9, 1'b0, 4'b1111, 4'hF, 4'h0, 4'h0, 4'hF);
    add("t1_release", 1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'hF, 4'hF);
    add("t1_idle",    1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0, 4'hF);
    add("t2_rst",     3, 1'b1, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0);
    add("t2_idle",    2, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0);
    // Clean press on key 0.
    add("t2_wait",    9, 1'b0, 4'b1110, 4'h0, 4'h0, 4'h0, 4'h0);
    add("t2_press",   1, 1'b0, 4'b1110, 4'h1, 4'h1, 4'h0, 4'h1);
    add("t2_hold",    1, 1'b0, 4'b1110, 4'h1, 4'h0, 4'h0, 4'h1);
    // Key 1 low for DB-1 cycles only: rejected.
    add("t3_glitch",  7, 1'b0, 4'b1100, 4'h1, 4'h0, 4'h0, 4'h1);
    add("t3_after",  12, 1'b0, 4'b1110, 4'h1, 4'h0, 4'h0, 4'h1);
    // Key 2 bounces in 2-cycle runs, then settles low.
    add("t4_bounce",  2, 1'b0, 4'b1010, 4'h1, 4'h0, 4'h0, 4'h1);
    add("t4_bounce",  2, 1'b0, 4'b1110, 4'h1, 4'h0, 4'h0, 4'h1);
    add("t4_bounce",  2, 1'b0, 4'b1010, 4'h1, 4'h0, 4'h0, 4'h1);
    add("t4_bounce",  2, 1'b0, 4'b1110, 4'h1, 4'h0, 4'h0, 4'h1);
    add("t4_wait",    9, 1'b0, 4'b1010, 4'h1, 4'h0, 4'h0, 4'h1);
    add("t4_press",   1, 1'b0, 4'b1010, 4'h5, 4'h4, 4'h0, 4'h5);
    add("t4_hold",    1, 1'b0, 4'b1010, 4'h5, 4'h0, 4'h0, 4'h5);
    add("t4_relwait", 9, 1'b0, 4'b1111, 4'h5, 4'h0, 4'h0, 4'h5);
    add("t4_release", 1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h5, 4'h5);
    add("t4_idle",    1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h5);
    add("t5_rst",     3, 1'b1, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0);
    add("t5_idle",    1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0);
    // Keys 3 and 2 together, twice.
    add("t5_wait1",   9, 1'b0, 4'b0011, 4'h0, 4'h0, 4'h0, 4'h0);
    add("t5_press1",  1, 1'b0, 4'b0011, 4'hC, 4'hC, 4'h0, 4'hC);
    add("t5_hold1",   1, 1'b0, 4'b0011, 4'hC, 4'h0, 4'h0, 4'hC);
    add("t5_relw1",   9, 1'b0, 4'b1111, 4'hC, 4'h0, 4'h0, 4'hC);
    add("t5_rel1",    1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'hC, 4'hC);
    add("t5_idle1",   1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0, 4'hC);
    add("t5_wait2",   9, 1'b0, 4'b0011, 4'h0, 4'h0, 4'h0, 4'hC);
    add("t5_press2",  1, 1'b0, 4'b0011, 4'hC, 4'hC, 4'h0, 4'h0);
    add("t5_hold2",   1, 1'b0, 4'b0011, 4'hC, 4'h0, 4'h0, 4'h0);
    add("t5_relw2",   9, 1'b0, 4'b1111, 4'hC, 4'h0, 4'h0, 4'h0);
    add("t5_rel2",    1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'hC, 4'h0);
    add("t5_idle2",   1, 1'b0, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0);
    // Reset while key 0 is pending at count 5.
    add("t6_pend",    7, 1'b0, 4'b1110, 4'h0, 4'h0, 4'h0, 4'h0);
    add("t6_rst",     2, 1'b1, 4'b1110, 4'h0, 4'h0, 4'h0, 4'h0);
    add("t6_wait",    9, 1'b0, 4'b1110, 4'h0, 4'h0, 4'h0, 4'h0);
    add("t6_press",   1, 1'b0, 4'b1110, 4'h1, 4'h1, 4'h0, 4'h1);
    add("t6_hold",    1, 1'b0, 4'b1110, 4'h1, 4'h0, 4'h0, 4'h1);
    // Release run of exactly DB cycles is accepted, then re-press.
    add("t7_short",   8, 1'b0, 4'b1111, 4'h1, 4'h0, 4'h0, 4'h1);
    add("t7_w",       1, 1'b0, 4'b1110, 4'h1, 4'h0, 4'h0, 4'h1);
    add("t7_release", 1, 1'b0, 4'b1110, 4'h0, 4'h0, 4'h1, 4'h1);
    add("t7_w2",      7, 1'b0, 4'b1110, 4'h0, 4'h0, 4'h0, 4'h1);
    add("t7_press",   1, 1'b0, 4'b1110, 4'h1, 4'h1, 4'h0, 4'h0);
    add("t7_hold",    1, 1'b0, 4'b1110, 4'h1, 4'h0, 4'h0, 4'h0);

    @(negedge FPGA_CLK);
    foreach (vecs[i]) begin
      drive_cycle(vecs[i].rst, vecs[i].key);
      check(vecs[i].name, vecs[i].exp);
    end

    // Randomised phase: per-key runs of 1..14 cycles straddle the DB boundary,
    // with occasional resets. Expected values come from the window model.
    cur_key = '1;
    for (int k = 0; k < NK; k++) seg_left[k] = $urandom_range(1, 14);
    for (int c = 0; c < 2; c++) begin
      model_step(1'b1, cur_key);
      drive_cycle(1'b1, cur_key);
      check("rnd_rst", exp_q.pop_front());
    end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (seg_left[k] == 0) begin
          cur_key[k]  = ~cur_key[k];
          seg_left[k] = $urandom_range(1, 14);
        end
        seg_left[k]--;
      end
      rnd_rst = ($urandom_range(0, 299) == 0);
      model_step(rnd_rst, cur_key);
      drive_cycle(rnd_rst, cur_key);
      check("rnd", exp_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
